fir_mac_secuencial: RTL and testbench
=====================================

Name: fir_mac_secuencial

Overview:
- Sequential FIR engine for the filter datapath, sitting directly upstream of the saturating signed adder.
- Holds the tapped delay line, the coefficient bank and the accumulator register.
- Computes one scaled, saturated tap product per cycle and presents it with the accumulator as adder operands; registers the adder result back each cycle.
- Emits one filtered sample per accepted input sample.

Parameters:
LARGO, 24, sign-bit index; all data, coefficients and operands are LARGO+1 bits signed two's complement
FRAC, 16, fractional bits of the coefficient format (1.0 = 2^FRAC)
TAPS, 5, number of filter taps (2..16)
AW, 4, coefficient address width; 2^AW >= TAPS

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  reset, synchronous and active-low
x_in  in  LARGO+1  input sample, signed
x_valid  in  1  x_in valid; accepted only when busy=0
busy  out  1  high while a sample is being processed
coef_we  in  1  coefficient write strobe
coef_addr  in  AW  coefficient index
coef_data  in  LARGO+1  coefficient value, signed, FRAC fractional bits
sum_a  out  LARGO+1  adder operand A = accumulator register
sum_b  out  LARGO+1  adder operand B = current scaled tap product
sum_y  in  LARGO+1  saturated sum returned by adder (combinational path)
y_out  out  LARGO+1  filtered output sample
y_valid  out  1  one-cycle pulse, y_out updated

Behaviour:
- Reset (rst_n=0 at clk edge): delay line, coefficient bank, accumulator, tap index, y_out all 0; y_valid=0, busy=0; FSM to IDLE. Overrides everything, including mid-MAC. No output is produced for an interrupted sample.
- FSM states: IDLE, MAC, DONE.
- IDLE:
  - busy=0, sum_b=0.
  - On x_valid=1: tap[k] <= tap[k-1] for k=TAPS-1..1; tap[0] <= x_in; acc <= 0; idx <= 0; go to MAC.
- MAC:
  - busy=1.
  - sum_b = sat(scale(tap[idx] * coef[idx])).
  - Each cycle: acc <= sum_y; idx <= idx+1.
  - After the cycle with idx=TAPS-1, go to DONE.
  - Exactly TAPS cycles.
- DONE:
  - busy=1.
  - y_out <= acc; y_valid=1 for this single cycle; go to IDLE.
- Latency: x_valid accepted at edge 0; y_valid high in cycle TAPS+1. Minimum sample spacing TAPS+2 cycles.
- sum_a = acc in all states.
- x_valid while busy=1: ignored and dropped; delay line unchanged.
- Product arithmetic:
  - full = tap*coef, 2*LARGO+2 bits signed.
  - Scaled = full >>> FRAC (arithmetic).
  - Saturate to [-(2^LARGO-1), 2^LARGO-1]: values above clamp to max, values below clamp to -(2^LARGO-1).
  - The most-negative code is never produced.
- Coefficient writes:
  - When coef_we=1 and busy=0, coef[coef_addr] <= coef_data at the edge.
  - Ignored when busy=1 or coef_addr >= TAPS.
  - Simultaneous x_valid and coef_we in IDLE: both take effect; the new coefficient is used for that sample.
- Delay line persists across samples (history) and is cleared only by reset.

Optional Feature:
- Macro FIR_MAC_ROUND_EN.
- Defined: scaled = (full + 2^(FRAC-1)) >>> FRAC (round half up) before saturation.
- Undefined: plain truncation (floor), as above.
- Saturation rules are identical in both builds.

Test Plan:
1. Impulse response (LARGO=24, FRAC=16, TAPS=5). Coefs {65536, 32768, 16384, 0, -65536}; send x=65536 then four x=0, each after y_valid → y_out sequence 65536, 32768, 16384, 0, -65536; y_valid exactly TAPS+1 cycles after each accept.
2. Product saturation: coef[0]=131072, other coefs 0; x=16777215 → y_out=16777215. Repeat with x=-16777215 → y_out=-16777215.
3. Busy drop: assert x_valid=1 continuously with x=100, coef[0]=65536 → samples accepted only every TAPS+2=7 cycles; busy high 6 cycles per sample; y_out=100 each output.
4. Reset mid-operation: drive rst_n=0 during MAC cycle 3 → next cycle busy=0, y_valid=0, y_out=0; no y_valid afterwards. Re-run impulse with reloaded coefficients → first output matches scenario 1.
5. Coefficient write rules: coef_we during busy → coefficient unchanged (checked via impulse). coef_addr=7 (≥TAPS) → no bank entry changes. Write in the same IDLE cycle as x_valid → new value used.
6. Rounding: coef[0]=32768, x=1. FIR_MAC_ROUND_EN undefined → y_out=0; defined → y_out=1. With x=-1: undefined → -1; defined → 0.

Source files
------------

// File: rtl/fir_mac_secuencial.sv
// rtl/fir_mac_secuencial.sv - sequential FIR tap MAC feeding an external saturating adder
// Optional FIR_MAC_ROUND_EN: round half up instead of floor when scaling tap products.
module fir_mac_secuencial #(
  parameter int LARGO = 24,
  parameter int FRAC  = 16,
  parameter int TAPS  = 5,
  parameter int AW    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic signed [LARGO:0] x_in,
  input  logic                x_valid,
  output logic                busy,
  input  logic                coef_we,
  input  logic [AW-1:0]       coef_addr,
  input  logic signed [LARGO:0] coef_data,
  output logic signed [LARGO:0] sum_a,
  output logic signed [LARGO:0] sum_b,
  input  logic signed [LARGO:0] sum_y,
  output logic signed [LARGO:0] y_out,
  output logic                y_valid
);
  localparam int W  = LARGO + 1;
  localparam int PW = 2 * W;

  // Symmetric clamp: the most-negative code is never emitted.
  localparam logic signed [PW-1:0] P_MAX = {{(W + 1){1'b0}}, {LARGO{1'b1}}};
  localparam logic signed [PW-1:0] P_MIN = -P_MAX;
  localparam logic signed [W-1:0]  Q_MAX = {1'b0, {LARGO{1'b1}}};
  localparam logic signed [W-1:0]  Q_MIN = -Q_MAX;
`ifdef FIR_MAC_ROUND_EN
  localparam logic signed [PW-1:0] HALF = PW'(1) << (FRAC - 1);
`endif

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t state, state_n;

  logic signed [W-1:0]  tap  [TAPS];
  logic signed [W-1:0]  coef [TAPS];
  logic signed [W-1:0]  acc;
  logic [AW-1:0]        idx;
  logic signed [W-1:0]  tap_sel, coef_sel, prod_sat;
  logic signed [PW-1:0] full, scaled;

  always_comb begin
    tap_sel  = '0;
    coef_sel = '0;
    for (int k = 0; k < TAPS; k++) begin
      if (idx == AW'(k)) begin
        tap_sel  = tap[k];
        coef_sel = coef[k];
      end
    end
  end

  always_comb begin
    full = PW'(tap_sel) * PW'(coef_sel);
`ifdef FIR_MAC_ROUND_EN
    scaled = (full + HALF) >>> FRAC;
`else
    scaled = full >>> FRAC;
`endif
    if (scaled > P_MAX)
      prod_sat = Q_MAX;
    else if (scaled < P_MIN)
      prod_sat = Q_MIN;
    else
      prod_sat = scaled[W-1:0];
  end

  assign busy  = (state != IDLE);
  assign sum_a = acc;
  assign sum_b = (state == MAC) ? prod_sat : '0;

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (x_valid) state_n = MAC;
      MAC:     if (idx == AW'(TAPS - 1)) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) begin
        tap[k]  <= '0;
        coef[k] <= '0;
      end
      acc     <= '0;
      idx     <= '0;
      y_out   <= '0;
      y_valid <= 1'b0;
    end else begin
      y_valid <= 1'b0;
      case (state)
        IDLE: begin
          // Out-of-range addresses match no entry and are dropped.
          if (coef_we) begin
            for (int k = 0; k < TAPS; k++)
              if (coef_addr == AW'(k)) coef[k] <= coef_data;
          end
          if (x_valid) begin
            tap[0] <= x_in;
            for (int k = 1; k < TAPS; k++) tap[k] <= tap[k-1];
            acc <= '0;
            idx <= '0;
          end
        end
        MAC: begin
          acc <= sum_y;
          idx <= idx + AW'(1);
        end
        DONE: begin
          y_out   <= acc;
          y_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_mac_secuencial.sv
// tb/tb_fir_mac_secuencial.sv - scoreboard bench for fir_mac_secuencial with a saturating adder model
module tb_fir_mac_secuencial;
  localparam int LARGO = 24;
  localparam int FRAC  = 16;
  localparam int TAPS  = 5;
  localparam int AW    = 4;
  localparam int W     = LARGO + 1;

  typedef logic signed [W-1:0] samp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  samp_t         x_in = '0;
  logic          x_valid = 1'b0;
  logic          busy;
  logic          coef_we = 1'b0;
  logic [AW-1:0] coef_addr = '0;
  samp_t         coef_data = '0;
  samp_t         sum_a, sum_b, sum_y, y_out;
  logic          y_valid;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  samp_t pend_y[$];
  samp_t exp_y[$];
  int    exp_t[$];
  bit    hold_chk = 1'b0;
  bit    have_last = 1'b0;
  int    last_acc = 0;
  int    busy_cnt = 0;

  fir_mac_secuencial #(.LARGO(LARGO), .FRAC(FRAC), .TAPS(TAPS), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .x_in(x_in), .x_valid(x_valid), .busy(busy),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .sum_a(sum_a), .sum_b(sum_b), .sum_y(sum_y), .y_out(y_out), .y_valid(y_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Downstream saturating adder, symmetric range.
  localparam logic signed [W:0] ADD_MAX = (W + 1)'((1 << LARGO) - 1);
  logic signed [W:0] add_raw;
  always_comb begin
    add_raw = (W + 1)'(sum_a) + (W + 1)'(sum_b);
    if (add_raw > ADD_MAX)
      sum_y = ADD_MAX[W-1:0];
    else if (add_raw < -ADD_MAX)
      sum_y = samp_t'(-ADD_MAX);
    else
      sum_y = add_raw[W-1:0];
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Accept detector: moves the next planned result into the scoreboard.
  always @(negedge clk) begin
    if (x_valid && !busy) begin
      if (hold_chk && have_last) begin
        chk("accept_spacing", cyc + 1 - last_acc, TAPS + 2);
        chk("busy_cycles", busy_cnt, TAPS + 1);
      end
      last_acc  = cyc + 1;
      have_last = 1'b1;
      busy_cnt  = 0;
      if (pend_y.size() == 0)
        chk("unexpected_accept", 1, 0);
      else begin
        exp_y.push_back(pend_y.pop_front());
        exp_t.push_back(cyc + 1 + TAPS + 1);
      end
    end else if (busy) begin
      busy_cnt++;
    end
  end

  always @(negedge clk) begin
    if (y_valid === 1'b1) begin
      if (exp_y.size() == 0)
        chk("unexpected_y_valid", 1, 0);
      else begin
        chk("y_out", y_out, exp_y.pop_front());
        chk("latency", cyc, exp_t.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  task automatic drain();
    int n = 0;
    while ((pend_y.size() != 0 || exp_y.size() != 0) && n < 60) begin
      tick();
      n++;
    end
    chk("drain_timeout", pend_y.size() + exp_y.size(), 0);
  endtask

  task automatic send(input samp_t x, input samp_t e);
    wait_idle();
    pend_y.push_back(e);
    x_in    = x;
    x_valid = 1'b1;
    tick();
    x_valid = 1'b0;
  endtask

  task automatic send_out(input samp_t x, input samp_t e);
    send(x, e);
    drain();
  endtask

  task automatic wcoef(input int addr, input samp_t data);
    coef_we   = 1'b1;
    coef_addr = AW'(addr);
    coef_data = data;
    tick();
    coef_we   = 1'b0;
  endtask

  task automatic load_impulse();
    wcoef(0, 65536);
    wcoef(1, 32768);
    wcoef(2, 16384);
    wcoef(3, 0);
    wcoef(4, -65536);
  endtask

  initial begin
    int n;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_y_valid", y_valid, 0);
    chk("rst_y_out", y_out, 0);
    chk("rst_sum_a", sum_a, 0);
    chk("rst_sum_b", sum_b, 0);
    rst_n = 1'b1;

    // Impulse response reproduces the coefficient bank.
    load_impulse();
    send_out(65536, 65536);
    send_out(0, 32768);
    send_out(0, 16384);
    send_out(0, 0);
    send_out(0, -65536);

    // Product saturation both directions.
    wcoef(0, 131072);
    for (int k = 1; k < TAPS; k++) wcoef(k, 0);
    send_out(16777215, 16777215);
    send_out(-16777215, -16777215);

    // x_valid held high: only one accept per TAPS+2 cycles.
    wcoef(0, 65536);
    wait_idle();
    have_last = 1'b0;
    hold_chk  = 1'b1;
    repeat (3) pend_y.push_back(100);
    x_in    = 100;
    x_valid = 1'b1;
    n = 0;
    while (pend_y.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    x_valid  = 1'b0;
    hold_chk = 1'b0;
    drain();

    // Reset during the third MAC cycle drops the sample.
    load_impulse();
    send(1234, 0);
    tick();
    tick();
    rst_n = 1'b0;
    exp_y.delete();
    exp_t.delete();
    tick();
    chk("midrst_busy", busy, 0);
    chk("midrst_y_valid", y_valid, 0);
    chk("midrst_y_out", y_out, 0);
    rst_n = 1'b1;
    repeat (12) tick();
    load_impulse();
    send_out(65536, 65536);

    // Write while busy is ignored: coef[1] stays 32768.
    send(0, 32768);
    wcoef(1, 0);
    drain();
    // Out-of-range address changes nothing.
    wcoef(7, 12345);
    send_out(0, 16384);
    // Write coincident with accept is used for that sample.
    wait_idle();
    coef_we   = 1'b1;
    coef_addr = AW'(0);
    coef_data = 131072;
    send(1000, 2000);
    coef_we = 1'b0;
    drain();

    // Rounding vs truncation of half-LSB products.
    wcoef(0, 32768);
    wcoef(1, 0);
    wcoef(2, 0);
    wcoef(4, 0);
`ifdef FIR_MAC_ROUND_EN
    send_out(1, 1);
    send_out(-1, 0);
`else
    send_out(1, 0);
    send_out(-1, -1);
`endif

    repeat (4) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
